// File: rtl/ps2_frame_controller.sv
// Receives one PS/2 keyboard frame from the debounced clock/data lines, checks it,
// tracks E0/F0 prefixes and hands finished scan codes to the consumer over valid/ack.
module ps2_frame_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       debouncedClock,
  input  logic       debouncedData,
  output logic [7:0] scanCode,
  output logic       isBreak,
  output logic       isExtended,
  output logic       scanValid,
  input  logic       scanAck,
  output logic       frameBusy,
  output logic       errParity,
  output logic       errStop,
  output logic       errTimeout,
  output logic       errOverrun
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
  // Timer hits TIMEOUT_CYCLES-1 on the increment out of this value.
  localparam logic [TimerW-1:0] TimerStop = TimerW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

  state_e            state_q, state_d;
  logic              prev_clk_q;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [9:0]        shift_q, shift_d;
  logic              ext_pend_q, ext_pend_d;
  logic              brk_pend_q, brk_pend_d;
  logic [7:0]        code_q, code_d;
  logic              brk_q, brk_d;
  logic              ext_q, ext_d;
  logic              valid_q, valid_d;
  logic              fall;
  logic [7:0]        rx_byte;
  logic              parity_ok, stop_ok;

  assign fall      = prev_clk_q & ~debouncedClock;
  // Start bit is not kept: after ten shifts data0..7 sit in [7:0], parity in [8], stop in [9].
  assign rx_byte   = shift_q[7:0];
  assign parity_ok = ^{rx_byte, shift_q[8]};
  assign stop_ok   = shift_q[9];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    timer_d    = timer_q;
    shift_d    = shift_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    code_d     = code_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    valid_d    = valid_q & ~scanAck;
    errParity  = 1'b0;
    errStop    = 1'b0;
    errTimeout = 1'b0;
    errOverrun = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall && !debouncedData) begin
          state_d   = StShift;
          bit_cnt_d = 4'd1;
          timer_d   = '0;
        end
      end
      StShift: begin
        if (fall) begin
          shift_d   = {debouncedData, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          timer_d   = '0;
          if (bit_cnt_q == 4'd10) state_d = StCheck;
        end else if (timer_q == TimerStop) begin
          errTimeout = 1'b1;
          state_d    = StIdle;
          timer_d    = '0;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (!parity_ok || !stop_ok) begin
          errParity  = ~parity_ok;
          errStop    = ~stop_ok;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else if (rx_byte == 8'hE0) begin
          ext_pend_d = 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk_pend_d = 1'b1;
        end else begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          if (!valid_q || scanAck) begin
            code_d  = rx_byte;
            brk_d   = brk_pend_q;
            ext_d   = ext_pend_q;
            valid_d = 1'b1;
          end else begin
            errOverrun = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      prev_clk_q <= 1'b1;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      shift_q    <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      code_q     <= '0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_clk_q <= debouncedClock;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      code_q     <= code_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      valid_q    <= valid_d;
    end
  end

  assign scanCode   = code_q;
  assign isBreak    = brk_q;
  assign isExtended = ext_q;
  assign scanValid  = valid_q;
  assign frameBusy  = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_frame_controller.sv
// Scoreboard bench: stimulus pushes expected codes/error pulses, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ps2_frame_controller;
  localparam int unsigned To   = 100;
  localparam int unsigned Half = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dclk = 1'b1;
  logic       ddat = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] scanCode;
  logic       isBreak, isExtended, scanValid, frameBusy;
  logic       errParity, errStop, errTimeout, errOverrun;

  ps2_frame_controller #(.TIMEOUT_CYCLES(To)) dut (
    .clk(clk), .rst(rst), .debouncedClock(dclk), .debouncedData(ddat),
    .scanCode(scanCode), .isBreak(isBreak), .isExtended(isExtended), .scanValid(scanValid),
    .scanAck(ack), .frameBusy(frameBusy), .errParity(errParity), .errStop(errStop),
    .errTimeout(errTimeout), .errOverrun(errOverrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] code; logic brk; logic ext;} code_t;
  typedef logic [3:0] err_t;  // {overrun, timeout, stop, parity}

  code_t exp_codes[$];
  err_t  exp_errs[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a new code is presented when valid rises or stays up across an ack.
  logic  prev_valid = 1'b0;
  logic  prev_ack = 1'b0;
  code_t e_code;
  err_t  e_err, got_err;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (scanValid && (!prev_valid || prev_ack)) begin
        if (exp_codes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got code %0h expected none", scanCode);
        end else begin
          e_code = exp_codes.pop_front();
          chk("scanCode", 32'(scanCode), 32'(e_code.code));
          chk("isBreak", 32'(isBreak), 32'(e_code.brk));
          chk("isExtended", 32'(isExtended), 32'(e_code.ext));
          chk("deliver_latency", 32'(cyc - fall_cyc), 32'd2);
        end
      end
      got_err = {errOverrun, errTimeout, errStop, errParity};
      if (got_err != 4'b0) begin
        if (exp_errs.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_error: got %b expected none", got_err);
        end else begin
          e_err = exp_errs.pop_front();
          chk("err_flags", 32'(got_err), 32'(e_err));
          chk("err_latency", 32'(cyc - fall_cyc), e_err[2] ? 32'(To - 1) : 32'd1);
        end
      end
      prev_valid = scanValid;
      prev_ack   = ack;
    end
  end

  task automatic send_bit(input logic b, input bit ack_here);
    ddat = b;
    repeat (Half) @(posedge clk);
    #1 dclk = 1'b0;
    fall_cyc = cyc;
    if (ack_here) begin
      @(posedge clk);
      #1 ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
      repeat (Half - 2) @(posedge clk);
    end else begin
      repeat (Half) @(posedge clk);
    end
    #1 dclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_flip, input logic stop,
                            input int nbits, input bit ack_stop);
    logic [10:0] f;
    f = {stop, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], ack_stop && (i == 10));
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic exp_code(input logic [7:0] c, input logic b, input logic x);
    code_t t;
    t = {c, b, x};
    exp_codes.push_back(t);
  endtask

  task automatic do_ack();
    chk("valid_before_ack", 32'(scanValid), 32'd1);
    @(posedge clk);
    #1 ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    chk("valid_after_ack", 32'(scanValid), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_scanCode", 32'(scanCode), 32'd0);
    chk("rst_flags", 32'({isBreak, isExtended, scanValid, frameBusy}), 32'd0);
    chk("rst_errs", 32'({errParity, errStop, errTimeout, errOverrun}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Plain make code
    exp_code(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    chk("busy_after_frame", 32'(frameBusy), 32'd0);
    do_ack();

    // Prefixed codes
    exp_code(8'h1C, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
    chk("no_output_on_prefix", 32'(scanValid), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    do_ack();
    exp_code(8'h75, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1, 11, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 11, 1'b0);
    do_ack();
    exp_code(8'h75, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 11, 1'b0);
    do_ack();

    // Parity and stop errors
    exp_errs.push_back(4'b0001);
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    chk("valid_after_parity_err", 32'(scanValid), 32'd0);
    exp_errs.push_back(4'b0010);
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
    chk("valid_after_stop_err", 32'(scanValid), 32'd0);
    exp_code(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    do_ack();

    // Watchdog: start + 4 data bits then silence
    exp_errs.push_back(4'b0100);
    send_frame(8'h1C, 1'b0, 1'b1, 5, 1'b0);
    chk("busy_mid_frame", 32'(frameBusy), 32'd1);
    repeat (To - Half - 10) @(posedge clk);
    #1 chk("busy_after_timeout", 32'(frameBusy), 32'd0);
    exp_code(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    do_ack();

    // Overrun, then delivery coinciding with ack
    exp_code(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    exp_errs.push_back(4'b1000);
    send_frame(8'h32, 1'b0, 1'b1, 11, 1'b0);
    chk("held_code_after_overrun", 32'(scanCode), 32'h1C);
    chk("valid_after_overrun", 32'(scanValid), 32'd1);
    exp_code(8'h32, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 11, 1'b1);
    chk("code_after_ack_delivery", 32'(scanCode), 32'h32);
    do_ack();

    // Reset mid-frame
    send_frame(8'h1C, 1'b0, 1'b1, 6, 1'b0);
    chk("busy_before_reset", 32'(frameBusy), 32'd1);
    rst = 1'b1;
    #1 chk_reset_outputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1 chk("idle_after_reset", 32'({frameBusy, scanValid}), 32'd0);
    exp_code(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    do_ack();

    repeat (20) @(posedge clk);
    #1;
    chk("codes_drained", 32'(exp_codes.size()), 32'd0);
    chk("errs_drained", 32'(exp_errs.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
